// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_arbiter
// Brief    : Round-robin scheduler sharing one pipelined FP multiplier among
//            N_REQ requesters. It registers the winning operands onto the
//            multiplier, tracks requester IDs through a tag pipeline matched
//            to the multiplier latency, and returns tagged responses on one
//            shared port.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_x,
  input  logic [N_REQ*32-1:0]  req_y,
  input  logic [N_REQ*3-1:0]   req_mode,
  output logic [31:0]          mul_fp_X,
  output logic [31:0]          mul_fp_Y,
  output logic [2:0]           mul_r_mode,
  input  logic [31:0]          mul_fp_Z,
  input  logic                 mul_ovrf,
  input  logic                 mul_udrf,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_z,
  output logic                 rsp_ovrf,
  output logic                 rsp_udrf,
  output logic                 busy
);

  // Highest requester index; the pointer wraps to zero after it.
  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(N_REQ - 1);

  // Round-robin pointer: requester with top priority this cycle.
  logic [ID_W-1:0]  r_ptr;

  // Arbitration results.
  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_win;
  logic             w_hs;

  // Winner's operands, selected from the flattened request buses.
  logic [31:0]      w_x;
  logic [31:0]      w_y;
  logic [2:0]       w_mode;

  // Issue stage tag: valid/ID of the operation now on the multiplier inputs.
  logic             r_iss_v;
  logic [ID_W-1:0]  r_iss_id;

  // Tag aligned with the multiplier output, plus any-stage-occupied flag.
  logic             w_last_v;
  logic [ID_W-1:0]  w_last_id;
  logic             w_tag_busy;

  // Hold masks every request so no grant is issued while it is high.
  assign w_cand = req_valid & {N_REQ{~hold}};

  // Find the first candidate at or after the pointer, wrapping around.
  always_comb begin
    int   pos;
    logic found;
    w_grant = '0;
    w_win   = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(r_ptr) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (pos == i) && w_cand[i]) begin
          found      = 1'b1;
          w_grant[i] = 1'b1;
          w_win      = ID_W'(i);
        end
      end
    end
  end

  assign req_ready = w_grant;
  assign w_hs      = |(req_valid & w_grant);

  // Steer the granted requester's operands toward the issue registers.
  always_comb begin
    w_x    = '0;
    w_y    = '0;
    w_mode = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_x    = req_x[i*32 +: 32];
        w_y    = req_y[i*32 +: 32];
        w_mode = req_mode[i*3 +: 3];
      end
    end
  end

  // Advance the pointer past the winner on every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_win == c_LAST_ID) ? '0 : w_win + ID_W'(1);
    end
  end

  // Issue stage: operands hold between grants, the valid tag pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_fp_X   <= '0;
      mul_fp_Y   <= '0;
      mul_r_mode <= '0;
      r_iss_v    <= 1'b0;
      r_iss_id   <= '0;
    end else begin
      r_iss_v <= w_hs;
      if (w_hs) begin
        mul_fp_X   <= w_x;
        mul_fp_Y   <= w_y;
        mul_r_mode <= w_mode;
        r_iss_id   <= w_win;
      end
    end
  end

  // Tag pipeline mirrors the multiplier depth; no stall, no backpressure.
  generate
    if (MUL_LAT == 0) begin : g_tag_comb
      // Combinational multiplier: the result belongs to the issue stage.
      assign w_last_v   = r_iss_v;
      assign w_last_id  = r_iss_id;
      assign w_tag_busy = 1'b0;
    end else begin : g_tag_pipe
      logic [MUL_LAT-1:0] r_tag_v;
      logic [ID_W-1:0]    r_tag_id [MUL_LAT];

      // Shift {valid, id} one stage per cycle behind the issue stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_v <= '0;
          for (int s = 0; s < MUL_LAT; s++) begin
            r_tag_id[s] <= '0;
          end
        end else begin
          r_tag_v[0]  <= r_iss_v;
          r_tag_id[0] <= r_iss_id;
          for (int s = 1; s < MUL_LAT; s++) begin
            r_tag_v[s]  <= r_tag_v[s-1];
            r_tag_id[s] <= r_tag_id[s-1];
          end
        end
      end

      assign w_last_v   = r_tag_v[MUL_LAT-1];
      assign w_last_id  = r_tag_id[MUL_LAT-1];
      assign w_tag_busy = |r_tag_v;
    end
  endgenerate

  // Capture the multiplier result with its owner's ID when the tag arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
    end else begin
      rsp_valid <= w_last_v;
      if (w_last_v) begin
        rsp_id   <= w_last_id;
        rsp_z    <= mul_fp_Z;
        rsp_ovrf <= mul_ovrf;
        rsp_udrf <= mul_udrf;
      end
    end
  end

  assign busy = r_iss_v | w_tag_busy | rsp_valid;

endmodule
`default_nettype wire
